// File: rtl/hmm_seq_ctrl.sv
// HMM sequence controller: double-buffers MFCC frames and
// drives per-model HMM scoring and the Viterbi write stream.
module hmm_seq_ctrl #(
    parameter int NUM_MODELS = 3,
    parameter int NFEAT      = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mfcc_dv,
    input  logic [4:0]  mfcc_index,
    input  logic [31:0] mfcc_x,
    output logic        hmm_start,
    output logic [1:0]  hmm_model,
    input  logic        hmm_load,
    input  logic [4:0]  hmm_rd_index,
    output logic [31:0] hmm_x,
    input  logic        hmm_ll_dv,
    input  logic [63:0] hmm_ll,
    input  logic        hmm_done,
    output logic        vit_write,
    output logic [1:0]  vit_model,
    output logic [31:0] vit_x,
    input  logic        vit_busy,
    output logic        frame_drop,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam int AW    = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [5:0] NF    = 6'(NFEAT);
    localparam logic [5:0] LAST  = 6'(NFEAT - 1);
    localparam logic [1:0] LASTM = 2'(NUM_MODELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_FLUSH,
        S_NEXT
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_buf [2][DEPTH];
    logic [1:0]  r_full;
    logic        r_fill_bank;
    logic        r_score_bank;
    logic        r_dropping;
    logic [1:0]  r_model;
    logic        r_pend;
    logic [31:0] r_pend_x;
    logic [31:0] r_hmm_x;
    logic        r_frame_drop;
    logic [7:0]  r_drop_cnt;

    logic        w_in_rng;
    logic        w_first;
    logic        w_last;
    logic        w_both;
    logic        w_discard;
    logic        w_wr;
    logic        w_active;
    logic        w_cap;
    logic        w_emit;
    logic        w_oldest;
    logic        w_ld_rng;
    logic        w_lastm;
    logic        w_go;
    logic        w_clr;
    logic        w_pos_ovf;
    logic        w_neg_ovf;
    logic [31:0] w_sat;

    assign w_in_rng  = {1'b0, mfcc_index} < NF;
    assign w_first   = (mfcc_index == 5'd0);
    assign w_last    = ({1'b0, mfcc_index} == LAST);
    assign w_both    = &r_full;
    // A frame is dropped as a whole once its first beat saw no room
    assign w_discard = w_first ? w_both : r_dropping;
    assign w_wr      = mfcc_dv && w_in_rng && !w_discard;
    assign w_active  = (r_state == S_RUN) || (r_state == S_FLUSH);
    assign w_cap     = w_active && hmm_ll_dv;
    assign w_emit    = r_pend && !vit_busy;
    // With both banks full the fill pointer has wrapped onto the oldest
    assign w_oldest  = w_both ? r_fill_bank : ~r_full[0];
    assign w_ld_rng  = {1'b0, hmm_rd_index} < NF;
    assign w_lastm   = (r_model >= LASTM);
    assign w_go      = (r_state == S_IDLE) && (|r_full);
    assign w_clr     = (r_state == S_NEXT) && w_lastm;

    assign w_pos_ovf = !hmm_ll[63] && (|hmm_ll[62:31]);
    assign w_neg_ovf = hmm_ll[63] && !(&hmm_ll[62:31]);
    assign w_sat     = w_pos_ovf ? 32'h7FFF_FFFF :
                       w_neg_ovf ? 32'h8000_0000 :
                       hmm_ll[31:0];

    // Frame buffer storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_fill_bank][mfcc_index[AW-1:0]] <= mfcc_x;
        end
    end

    // Bank full flags, fill pointer and frame drop accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full       <= 2'b00;
            r_fill_bank  <= 1'b0;
            r_dropping   <= 1'b0;
            r_frame_drop <= 1'b0;
            r_drop_cnt   <= 8'd0;
        end else begin
            r_frame_drop <= 1'b0;
            if (mfcc_dv && w_in_rng && w_first) begin
                r_dropping <= w_both;
                if (w_both) begin
                    r_frame_drop <= 1'b1;
                    if (r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                end
            end
            if (w_wr && w_last) begin
                r_full[r_fill_bank] <= 1'b1;
                r_fill_bank         <= ~r_fill_bank;
            end
            if (w_clr) begin
                r_full[r_score_bank] <= 1'b0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_next    = r_state;
        hmm_start = 1'b0;
        busy      = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                if (|r_full) w_next = S_START;
            end
            S_START: begin
                hmm_start = 1'b1;
                w_next    = S_RUN;
            end
            S_RUN: begin
                if (hmm_done) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (!r_pend) w_next = S_NEXT;
            end
            S_NEXT: begin
                w_next = w_lastm ? S_IDLE : S_START;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Model counter, score bank, likelihood holding reg, feature readback
    always_ff @(posedge clk) begin
        if (reset) begin
            r_model      <= 2'd0;
            r_score_bank <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_x     <= 32'd0;
            r_hmm_x      <= 32'd0;
        end else begin
            if (w_go) begin
                r_score_bank <= w_oldest;
                r_model      <= 2'd0;
            end
            if ((r_state == S_NEXT) && !w_lastm) begin
                r_model <= r_model + 2'd1;
            end
            if (w_cap) begin
                r_pend   <= 1'b1;
                r_pend_x <= w_sat;
            end else if (w_emit) begin
                r_pend <= 1'b0;
            end
            if (w_active && hmm_load) begin
                r_hmm_x <= w_ld_rng ?
                    r_buf[r_score_bank][hmm_rd_index[AW-1:0]] :
                    32'd0;
            end
        end
    end

    assign hmm_model  = r_model;
    assign hmm_x      = r_hmm_x;
    assign vit_write  = w_emit;
    assign vit_model  = r_model;
    assign vit_x      = r_pend_x;
    assign frame_drop = r_frame_drop;
    assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_hmm_seq_ctrl.sv
// Scoreboard bench for hmm_seq_ctrl: stimulus pushes expected
// starts/writes, monitor pops and compares on the falling edge.
module tb_hmm_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mfcc_dv;
    logic [4:0]  mfcc_index;
    logic [31:0] mfcc_x;
    logic        hmm_start;
    logic [1:0]  hmm_model;
    logic        hmm_load;
    logic [4:0]  hmm_rd_index;
    logic [31:0] hmm_x;
    logic        hmm_ll_dv;
    logic [63:0] hmm_ll;
    logic        hmm_done;
    logic        vit_write;
    logic [1:0]  vit_model;
    logic [31:0] vit_x;
    logic        vit_busy;
    logic        frame_drop;
    logic [7:0]  drop_cnt;
    logic        busy;

    hmm_seq_ctrl #(.NUM_MODELS(3), .NFEAT(13)) dut (
        .clk(clk), .reset(reset),
        .mfcc_dv(mfcc_dv), .mfcc_index(mfcc_index), .mfcc_x(mfcc_x),
        .hmm_start(hmm_start), .hmm_model(hmm_model),
        .hmm_load(hmm_load), .hmm_rd_index(hmm_rd_index), .hmm_x(hmm_x),
        .hmm_ll_dv(hmm_ll_dv), .hmm_ll(hmm_ll), .hmm_done(hmm_done),
        .vit_write(vit_write), .vit_model(vit_model), .vit_x(vit_x),
        .vit_busy(vit_busy), .frame_drop(frame_drop),
        .drop_cnt(drop_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] x;
    } wr_t;

    wr_t         wq[$];
    logic [1:0]  sq[$];
    wr_t         e_wr;
    logic [1:0]  e_m;
    int          n_cmp = 0;
    int          n_err = 0;
    int          drop_pulses = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every DUT write/start against the scoreboard
    always @(negedge clk) begin
        if (vit_write === 1'b1) begin
            chk("vit_busy_at_write", 64'(vit_busy), 64'd0);
            if (wq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_vit_write: got m=%0d x=%0h expected none",
                         vit_model, vit_x);
            end else begin
                e_wr = wq.pop_front();
                chk("vit_model", 64'(vit_model), 64'(e_wr.m));
                chk("vit_x", 64'(vit_x), 64'(e_wr.x));
            end
        end
        if (hmm_start === 1'b1) begin
            if (sq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_hmm_start: got m=%0d expected none",
                         hmm_model);
            end else begin
                e_m = sq.pop_front();
                chk("hmm_model", 64'(hmm_model), 64'(e_m));
            end
        end
        if (frame_drop === 1'b1) drop_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int base);
        for (int k = 0; k < 13; k++) begin
            mfcc_dv    = 1'b1;
            mfcc_index = 5'(k);
            mfcc_x     = 32'(base + k);
            tick();
        end
        mfcc_dv = 1'b0;
    endtask

    task automatic begin_model(input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        sq.push_back(m);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (hmm_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_timeout: got none expected model %0d", m);
        end
        tick();
    endtask

    task automatic finish_model(input logic [63:0] ll,
                                input logic [31:0] ex,
                                input logic [1:0] m);
        hmm_ll_dv = 1'b1;
        hmm_ll    = ll;
        wq.push_back('{m: m, x: ex});
        tick();
        hmm_ll_dv = 1'b0;
        hmm_done  = 1'b1;
        tick();
        hmm_done  = 1'b0;
    endtask

    task automatic load_check(input logic [4:0] idx,
                              input logic [31:0] exp,
                              input string name);
        hmm_load     = 1'b1;
        hmm_rd_index = idx;
        tick();
        hmm_load = 1'b0;
        @(negedge clk);
        chk(name, 64'(hmm_x), 64'(exp));
        tick();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        chk(name, 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int saw;
        reset        = 1'b1;
        mfcc_dv      = 1'b0;
        mfcc_index   = 5'd0;
        mfcc_x       = 32'd0;
        hmm_load     = 1'b0;
        hmm_rd_index = 5'd0;
        hmm_ll_dv    = 1'b0;
        hmm_ll       = 64'd0;
        hmm_done     = 1'b0;
        vit_busy     = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hmm_start", 64'(hmm_start), 64'd0);
        chk("rst_vit_write", 64'(vit_write), 64'd0);
        chk("rst_frame_drop", 64'(frame_drop), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_hmm_x", 64'(hmm_x), 64'd0);
        chk("rst_vit_x", 64'(vit_x), 64'd0);
        chk("rst_models", 64'({hmm_model, vit_model}), 64'd0);
        reset = 1'b0;
        tick();

        // basic frame, three models with ll=5
        send_frame(0);
        for (int m = 0; m < 3; m++) begin
            begin_model(2'(m));
            finish_model(64'd5, 32'd5, 2'(m));
        end
        wait_idle("idle_after_basic");

        // feature readback and saturation
        send_frame(100);
        begin_model(2'd0);
        load_check(5'd7, 32'd107, "hmm_x_idx7");
        load_check(5'd20, 32'd0, "hmm_x_idx20");
        load_check(5'd12, 32'd112, "hmm_x_idx12");
        load_check(5'd0, 32'd100, "hmm_x_idx0");
        finish_model(64'h0000_0001_0000_0000, 32'h7FFF_FFFF, 2'd0);
        begin_model(2'd1);
        finish_model(64'hFFFF_FFFE_0000_0000, 32'h8000_0000, 2'd1);
        begin_model(2'd2);
        finish_model(-64'sd3, 32'hFFFF_FFFD, 2'd2);
        wait_idle("idle_after_sat");

        send_frame(50);
        begin_model(2'd0);
        finish_model(64'h0000_0000_7FFF_FFFF, 32'h7FFF_FFFF, 2'd0);
        begin_model(2'd1);
        finish_model(64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 2'd1);
        begin_model(2'd2);
        finish_model(64'h0000_0000_8000_0000, 32'h7FFF_FFFF, 2'd2);
        wait_idle("idle_after_sat_edges");

        // Viterbi back-pressure, overwrite, ll+done together
        send_frame(10);
        begin_model(2'd0);
        vit_busy  = 1'b1;
        hmm_ll_dv = 1'b1;
        hmm_ll    = 64'd9;
        tick();
        hmm_ll   = 64'd11;
        hmm_done = 1'b1;
        wq.push_back('{m: 2'd0, x: 32'd11});
        tick();
        hmm_ll_dv = 1'b0;
        hmm_done  = 1'b0;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hmm_start === 1'b1) saw++;
            tick();
        end
        vit_busy = 1'b0;
        chk("no_start_while_vit_busy", 64'(saw), 64'd0);
        @(negedge clk);
        chk("write_on_release", 64'(vit_write), 64'd1);
        tick();
        begin_model(2'd1);
        finish_model(64'd21, 32'd21, 2'd1);
        begin_model(2'd2);
        finish_model(64'd22, 32'd22, 2'd2);
        wait_idle("idle_after_backpressure");

        // stalled HMM, three frames back-to-back
        drop_pulses = 0;
        sq.push_back(2'd0);
        send_frame(200);
        send_frame(300);
        send_frame(400);
        tick();
        chk("drop_pulses", 64'(drop_pulses), 64'd1);
        chk("drop_cnt_1", 64'(drop_cnt), 64'd1);
        load_check(5'd3, 32'd203, "frameA_idx3");
        finish_model(64'd31, 32'd31, 2'd0);
        begin_model(2'd1);
        finish_model(64'd32, 32'd32, 2'd1);
        begin_model(2'd2);
        finish_model(64'd33, 32'd33, 2'd2);
        begin_model(2'd0);
        load_check(5'd3, 32'd303, "frameB_idx3");
        load_check(5'd12, 32'd312, "frameB_idx12");
        finish_model(64'd41, 32'd41, 2'd0);
        begin_model(2'd1);
        finish_model(64'd42, 32'd42, 2'd1);
        begin_model(2'd2);
        finish_model(64'd43, 32'd43, 2'd2);
        wait_idle("idle_after_drop");
        chk("drop_cnt_still_1", 64'(drop_cnt), 64'd1);

        // reset in RUN with a pending likelihood
        send_frame(500);
        begin_model(2'd0);
        vit_busy  = 1'b1;
        hmm_ll_dv = 1'b1;
        hmm_ll    = 64'd77;
        tick();
        hmm_ll_dv = 1'b0;
        reset     = 1'b1;
        tick();
        vit_busy = 1'b0;
        @(negedge clk);
        chk("rst_run_busy", 64'(busy), 64'd0);
        chk("rst_run_vit_write", 64'(vit_write), 64'd0);
        chk("rst_run_vit_x", 64'(vit_x), 64'd0);
        chk("rst_run_drop_cnt", 64'(drop_cnt), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        send_frame(600);
        begin_model(2'd0);
        load_check(5'd0, 32'd600, "post_rst_idx0");
        finish_model(64'd1, 32'd1, 2'd0);
        begin_model(2'd1);
        finish_model(64'd2, 32'd2, 2'd1);
        begin_model(2'd2);
        finish_model(64'd3, 32'd3, 2'd2);
        wait_idle("idle_after_reset_frame");

        repeat (20) tick();
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("sq_empty", 64'(sq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hmm_seq_ctrl.md
HMM_SEQ_CTRL -- requirements
Module: hmm_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_MODELS, default 3, meaning the number of word/garbage models scored per MFCC frame (range 1..4).
REQ-002 The block SHALL have parameter NFEAT, default 13, meaning the number of MFCC coefficients per frame (range 1..32).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; ports `clk` and `reset`.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mfcc_dv  in  1  MFCC coefficient valid
- mfcc_index  in  5  coefficient index 0..NFEAT-1
- mfcc_x  in  32  signed coefficient
- hmm_start  out  1  one-cycle pulse starting one model evaluation
- hmm_model  out  2  model being evaluated, stable from start to done
- hmm_load  in  1  HMM feature read request
- hmm_rd_index  in  5  requested coefficient index
- hmm_x  out  32  requested coefficient, valid the cycle after hmm_load
- hmm_ll_dv  in  1  likelihood valid
- hmm_ll  in  64  signed log-likelihood
- hmm_done  in  1  model evaluation finished
- vit_write  out  1  one-cycle likelihood write to Viterbi
- vit_model  out  2  model index of vit_x
- vit_x  out  32  saturated signed likelihood
- vit_busy  in  1  Viterbi cannot accept a write
- frame_drop  out  1  one-cycle pulse when a frame is discarded
- drop_cnt  out  8  saturating count of dropped frames
- busy  out  1  high in any state other than IDLE

Function
REQ-005 The block SHALL buffer frames in two banks of NFEAT x 32 bits; a write stores mfcc_x at [fill_bank][mfcc_index] when mfcc_dv=1.
REQ-006 A bank SHALL be marked full on the cycle after mfcc_dv with mfcc_index=NFEAT-1; fill_bank SHALL then toggle to the other bank.
REQ-007 If both banks are full at the first coefficient of a frame (mfcc_index=0), the whole frame SHALL be discarded, frame_drop SHALL pulse once, and drop_cnt SHALL increment, saturating at 255.
REQ-008 mfcc_index >= NFEAT SHALL be ignored (no write, no state change).
REQ-009 FSM states SHALL be IDLE, START, RUN, FLUSH, NEXT.
REQ-010 IDLE -> START when any bank is full; the oldest full bank becomes the score bank; model counter = 0.
REQ-011 In START, hmm_start=1 for exactly one cycle with hmm_model = model counter; next state RUN.
REQ-012 In RUN, hmm_load=1 SHALL return hmm_x = score_bank[hmm_rd_index] on the next cycle; an index >= NFEAT SHALL return 0.
REQ-013 In RUN, hmm_ll_dv=1 SHALL capture hmm_ll saturated to 32 bits: above 0x7FFFFFFF -> 0x7FFFFFFF; below -0x80000000 -> 0x80000000; otherwise the low 32 bits.
REQ-014 A captured likelihood SHALL be emitted as a one-cycle vit_write with vit_model = model counter on the first cycle with vit_busy=0; minimum latency is 1 cycle after hmm_ll_dv.
REQ-015 The holding register SHALL hold one likelihood; hmm_ll_dv while a likelihood is pending SHALL overwrite it (last value wins).
REQ-016 hmm_done in RUN -> FLUSH; FLUSH waits until no write is pending -> NEXT.
REQ-017 hmm_done and hmm_ll_dv in the same cycle SHALL capture the likelihood, then enter FLUSH.
REQ-018 In NEXT: if model counter < NUM_MODELS-1, increment the counter and go to START; otherwise clear the score bank's full flag and go to IDLE.
REQ-019 A frame filling the score bank's partner during scoring SHALL NOT disturb the score bank.
REQ-020 hmm_done, hmm_load and hmm_ll_dv outside RUN/FLUSH SHALL be ignored.

Reset
REQ-021 reset SHALL take effect at the next clk edge, including mid-frame or mid-scoring, and SHALL set:
- state = IDLE; both banks empty; fill_bank = 0
- hmm_start = 0, vit_write = 0, frame_drop = 0, busy = 0
- hmm_model = 0, vit_model = 0, vit_x = 0, hmm_x = 0, drop_cnt = 0
- pending likelihood cleared
REQ-022 Buffer contents need not be cleared by reset.

Verification
REQ-023 One 13-coefficient frame, HMM model returns ll=5, done -> three hmm_start pulses (hmm_model 0,1,2); three vit_write with vit_x=5 and vit_model 0,1,2; then busy=0.
REQ-024 hmm_ll=0x0000_0001_0000_0000 -> vit_x=0x7FFFFFFF; hmm_ll=0xFFFF_FFFE_0000_0000 -> vit_x=0x80000000; hmm_ll=-3 -> vit_x=0xFFFFFFFD.
REQ-025 vit_busy held high 10 cycles across hmm_ll_dv and hmm_done -> no vit_write while busy; exactly one vit_write on the first cycle vit_busy=0; hmm_start for the next model only after that write.
REQ-026 HMM stalled, three frames delivered back-to-back -> third frame dropped, frame_drop pulses once, drop_cnt=1; the first two frames are scored in order.
REQ-027 Frame with coefficient k = k+100; hmm_load with hmm_rd_index=7 -> hmm_x=107 next cycle; hmm_rd_index=20 -> hmm_x=0.
REQ-028 reset asserted in RUN with a pending likelihood -> next cycle state IDLE, busy=0, no vit_write; a new frame afterwards is scored starting at model 0.
